id_stage_pipelined: RTL and testbench
=====================================

Name: id_stage_pipelined

Overview:
- Parametrised, registered decode stage: IF/ID pipeline register, decoder, immediate generator, register file with write-through bypass, multi-cycle load-use hazard unit, and ID/EX output register.
- Sits between fetch and execute.
- Adds over the prior decode logic: configurable XLEN/register count/load-use penalty, flush, valid tracking, and source-usage-qualified hazard checks.

Parameters:
- XLEN, 64, datapath/register width (32 or 64).
- NREGS, 32, architectural register count (power of 2, min 2); AW = clog2(NREGS).
- LOAD_STALL, 1, bubbles inserted on a load-use hazard (1..3).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- if_valid  in  1  fetch presents a valid instruction.
- if_instr  in  32  fetched instruction.
- if_pc  in  XLEN  PC of if_instr.
- flush  in  1  kill IF/ID and ID/EX contents (branch/jump redirect).
- if_stall  out  1  hold PC/fetch this cycle (combinational).
- wb_regwrite  in  1  writeback enable.
- wb_rd  in  AW  writeback destination.
- wb_data  in  XLEN  writeback data.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_pc  out  XLEN  registered PC.
- ex_rs1_data, ex_rs2_data  out  XLEN each  registered operands.
- ex_imm  out  XLEN  registered immediate.
- ex_rs1, ex_rs2, ex_rd  out  AW each  registered register indices.
- ex_funct3  out  3  registered funct3.
- ex_funct7  out  7  registered funct7.
- ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite  out  1 each  registered controls.
- ex_aluop  out  2  registered ALU op class.

Behaviour:
- Reset (clk edge with reset=1): IF/ID valid=0; all ID/EX outputs=0 (ex_valid=0); stall counter=0; all registers=0. Reset overrides flush and stall.
- Latency: instruction accepted at edge N appears on ex_* at edge N+1 when no stall.
- IF/ID capture: if !if_stall, register if_instr/if_pc with valid=if_valid. If if_stall, hold.
- Decode (from IF/ID contents):
  - Field extraction: standard RV32 positions.
  - Immediates (I/S/B/U/J) sign-extended to XLEN from instr[31]; U-type is imm[31:12]<<12, then sign-extended.
  - Unknown opcode gives imm=0.
- Control per opcode:
  - R 0110011: regwrite, aluop=10.
  - OP-IMM 0010011: regwrite, alusrc.
  - LOAD 0000011: regwrite, alusrc, memread, memtoreg.
  - STORE 0100011: memwrite, alusrc.
  - BRANCH 1100011: branch, aluop=01.
  - JAL 1101111 / JALR 1100111 / LUI 0110111 / AUIPC 0010111: regwrite, alusrc.
  - Other opcodes: all controls 0; ex_valid still follows the valid bit.
- Source usage:
  - rs1 used by R, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - rs2 used by R, STORE, BRANCH.
- Register file:
  - Write on posedge when wb_regwrite and wb_rd!=0.
  - Combinational read. Index 0 always reads 0.
  - Bypass: if wb_regwrite && wb_rd==read index && index!=0, read returns wb_data in the same cycle.
- Hazard detect: hz = IF/ID valid & ex_valid & ex_memread & ex_rd!=0 & ((rs1_used & ex_rd==rs1) | (rs2_used & ex_rd==rs2)).
- Stall counter cnt:
  - On hz with cnt==0, load LOAD_STALL-1.
  - While cnt!=0, decrement each cycle.
  - if_stall = hz | (cnt!=0).
- During if_stall: IF/ID holds; ID/EX loads a bubble (ex_valid=0, all controls 0, data fields 0).
- While counting, ID/EX holds the bubble. The load leaves ID/EX after the first bubble, so later cycles are held by cnt alone.
- Flush (priority over stall): at edge, IF/ID valid=0, ID/EX bubble, cnt=0; if_stall ignored that cycle.
- Invalid IF/ID entry never raises hz and produces a bubble.
- No XLEN truncation: wb_data is written full width.

Decomposition:
- Package rv_pkg:
  - Opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC).
  - ALUOp encodings (ALU_ADD=00, ALU_BR=01, ALU_FUNCT=10).
  - ctrl_t struct {branch, memread, memtoreg, aluop, memwrite, alusrc, regwrite}.
- Sub-module rv_regfile #(XLEN,NREGS): storage, reset clear, bypassed read ports.
- Decode, immediate generation and hazard logic stay inline.

Test Plan:
- Basic decode: reset, then `addi x5,x0,-1` (0xFFF00293) with if_valid=1 -> next edge: ex_valid=1, ex_imm=0xFFFF_FFFF_FFFF_FFFF, ex_rd=5, ex_regwrite=1, ex_alusrc=1, ex_aluop=00.
- Load-use, LOAD_STALL=1: `lw x6,0(x1)` then `add x7,x6,x2` -> if_stall=1 one cycle, one bubble (ex_valid=0), then add issues with ex_rs1=6.
- No false stall: `lw x6` then `sw x6,0(x3)` (rs2) stalls. `lw x6` then `lui x6,1` (rs unused) and `lw x0` then `add x7,x0,x0` never assert if_stall.
- Multi-cycle stall, LOAD_STALL=3: load-use pair -> exactly 3 consecutive if_stall cycles and 3 bubbles. Assert flush in the 2nd stall cycle -> cnt cleared, if_stall=0 next cycle, ex_valid=0.
- Bypass and x0: wb_regwrite=1, wb_rd=9, wb_data=0x1234 while decoding `add x10,x9,x0` -> ex_rs1_data=0x1234 the same edge, ex_rs2_data=0. A write to x0 keeps reads of x0 at 0.
- Reset mid-operation: reset asserted during an active stall and with valid ID/EX -> next edge ex_valid=0, if_stall=0 (if IF/ID invalid), all registers read 0; XLEN=32 variant: B-type imm -4 gives 0xFFFF_FFFC.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared decode definitions: RV32 opcodes, ALU op classes, control bundle.
// No ports; imported by the decode stage and the register file.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_BR    = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic [1:0] aluop;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
    } ctrl_t;

endpackage

// File: rtl/rv_regfile.sv
// Register file, two bypassed combinational read ports, x0 hardwired to 0.
// Ports: clk, reset, we_i/waddr_i/wdata_i write port, raddr*_i -> rdata*_o.
module rv_regfile
    import rv_pkg::*;
#(
    parameter  int XLEN  = 64,
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr1_i,
    input  logic [AW-1:0]   raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_en;

    assign wr_en = we_i && (waddr_i != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Write-through: a same-cycle writeback is visible to decode.
    always_comb begin
        rdata1_o = regs_q[raddr1_i];
        if (raddr1_i == '0) begin
            rdata1_o = '0;
        end else if (wr_en && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
    end

    always_comb begin
        rdata2_o = regs_q[raddr2_i];
        if (raddr2_i == '0) begin
            rdata2_o = '0;
        end else if (wr_en && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
    end

endmodule

// File: rtl/id_stage_pipelined.sv
// Registered decode stage: IF/ID reg, decode, immgen, regfile, load-use stall, ID/EX reg.
// Ports: fetch (if_*), flush, if_stall, writeback (wb_*), registered execute bundle (ex_*).
module id_stage_pipelined
    import rv_pkg::*;
#(
    parameter  int XLEN       = 64,
    parameter  int NREGS      = 32,
    parameter  int LOAD_STALL = 1,
    localparam int AW         = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    output logic            if_stall,
    input  logic            wb_regwrite,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [AW-1:0]   ex_rs1,
    output logic [AW-1:0]   ex_rs2,
    output logic [AW-1:0]   ex_rd,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
    output logic            ex_branch,
    output logic            ex_memread,
    output logic            ex_memtoreg,
    output logic            ex_memwrite,
    output logic            ex_alusrc,
    output logic            ex_regwrite,
    output logic [1:0]      ex_aluop
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [AW-1:0]   rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        ctrl_t           ctrl;
    } id_ex_t;

    localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL - 1);

    logic            ifid_valid_q;
    logic [31:0]     ifid_instr_q;
    logic [XLEN-1:0] ifid_pc_q;
    logic [1:0]      cnt_q, cnt_d;
    id_ex_t          id_ex_q, id_ex_d;

    logic [6:0]      opcode;
    logic [AW-1:0]   rs1, rs2, rd;
    logic [31:0]     ins;
    logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
    logic [XLEN-1:0] rs1_data, rs2_data;
    ctrl_t           ctrl;
    logic            rs1_used, rs2_used;
    logic            hz, stall;

    assign ins    = ifid_instr_q;
    assign opcode = ins[6:0];
    assign rd     = AW'(ins[11:7]);
    assign rs1    = AW'(ins[19:15]);
    assign rs2    = AW'(ins[24:20]);

    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};

    always_comb begin
        ctrl     = '0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        imm32    = '0;
        unique case (opcode)
            OP_R: begin
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALU_FUNCT;
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
            end
            OP_IMM: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                rs1_used      = 1'b1;
                imm32         = imm_i;
            end
            OP_LOAD: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.memtoreg = 1'b1;
                rs1_used      = 1'b1;
                imm32         = imm_i;
            end
            OP_STORE: begin
                ctrl.memwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
                imm32         = imm_s;
            end
            OP_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.aluop  = ALU_BR;
                rs1_used    = 1'b1;
                rs2_used    = 1'b1;
                imm32       = imm_b;
            end
            OP_JAL: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                imm32         = imm_j;
            end
            OP_JALR: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                rs1_used      = 1'b1;
                imm32         = imm_i;
            end
            OP_LUI, OP_AUIPC: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                imm32         = imm_u;
            end
            default: begin
            end
        endcase
    end

    rv_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we_i     (wb_regwrite),
        .waddr_i  (wb_rd),
        .wdata_i  (wb_data),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rs1_data),
        .rdata2_o (rs2_data)
    );

    // Only the first stall cycle sees the load in ID/EX; the counter
    // covers the remaining LOAD_STALL-1 cycles.
    assign hz = ifid_valid_q && id_ex_q.valid && id_ex_q.ctrl.memread
             && (id_ex_q.rd != '0)
             && ((rs1_used && (id_ex_q.rd == rs1))
              || (rs2_used && (id_ex_q.rd == rs2)));

    assign stall    = hz || (cnt_q != '0);
    assign if_stall = stall;

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 2'd1;
        end else if (hz) begin
            cnt_d = STALL_INIT;
        end
    end

    always_comb begin
        id_ex_d = '0;
        if (ifid_valid_q && !stall && !flush) begin
            id_ex_d.valid    = 1'b1;
            id_ex_d.pc       = ifid_pc_q;
            id_ex_d.rs1_data = rs1_data;
            id_ex_d.rs2_data = rs2_data;
            id_ex_d.imm      = XLEN'($signed(imm32));
            id_ex_d.rs1      = rs1;
            id_ex_d.rs2      = rs2;
            id_ex_d.rd       = rd;
            id_ex_d.funct3   = ins[14:12];
            id_ex_d.funct7   = ins[31:25];
            id_ex_d.ctrl     = ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
            cnt_q        <= '0;
            id_ex_q      <= '0;
        end else begin
            cnt_q   <= cnt_d;
            id_ex_q <= id_ex_d;
            if (flush) begin
                ifid_valid_q <= 1'b0;
            end else if (!stall) begin
                ifid_valid_q <= if_valid;
                ifid_instr_q <= if_instr;
                ifid_pc_q    <= if_pc;
            end
        end
    end

    assign ex_valid    = id_ex_q.valid;
    assign ex_pc       = id_ex_q.pc;
    assign ex_rs1_data = id_ex_q.rs1_data;
    assign ex_rs2_data = id_ex_q.rs2_data;
    assign ex_imm      = id_ex_q.imm;
    assign ex_rs1      = id_ex_q.rs1;
    assign ex_rs2      = id_ex_q.rs2;
    assign ex_rd       = id_ex_q.rd;
    assign ex_funct3   = id_ex_q.funct3;
    assign ex_funct7   = id_ex_q.funct7;
    assign ex_branch   = id_ex_q.ctrl.branch;
    assign ex_memread  = id_ex_q.ctrl.memread;
    assign ex_memtoreg = id_ex_q.ctrl.memtoreg;
    assign ex_memwrite = id_ex_q.ctrl.memwrite;
    assign ex_alusrc   = id_ex_q.ctrl.alusrc;
    assign ex_regwrite = id_ex_q.ctrl.regwrite;
    assign ex_aluop    = id_ex_q.ctrl.aluop;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Scoreboard bench for id_stage_pipelined: a 64-bit/1-bubble instance and a
// 32-bit/3-bubble instance share stimulus; one monitor checks issued bundles.
module tb_id_stage_pipelined;

    typedef struct {
        logic [63:0] pc, a, b, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [7:0]  ctl;
        int          gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, sel;
    logic        if_valid, flush, wb_regwrite;
    logic [31:0] if_instr;
    logic [63:0] if_pc, wb_data;
    logic [4:0]  wb_rd;

    logic        a_stall, a_valid, a_br, a_mr, a_mtr, a_mw, a_as, a_rw;
    logic [63:0] a_pc, a_rd1, a_rd2, a_imm;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [2:0]  a_f3;
    logic [6:0]  a_f7;
    logic [1:0]  a_aluop;

    logic        b_stall, b_valid, b_br, b_mr, b_mtr, b_mw, b_as, b_rw;
    logic [31:0] b_pc, b_rd1, b_rd2, b_imm;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [2:0]  b_f3;
    logic [6:0]  b_f7;
    logic [1:0]  b_aluop;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    id_stage_pipelined #(.XLEN(64), .NREGS(32), .LOAD_STALL(1)) dut_a (
        .clk(clk), .reset(rst_a), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .flush(flush), .if_stall(a_stall),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(a_valid), .ex_pc(a_pc), .ex_rs1_data(a_rd1),
        .ex_rs2_data(a_rd2), .ex_imm(a_imm), .ex_rs1(a_rs1), .ex_rs2(a_rs2),
        .ex_rd(a_rd), .ex_funct3(a_f3), .ex_funct7(a_f7), .ex_branch(a_br),
        .ex_memread(a_mr), .ex_memtoreg(a_mtr), .ex_memwrite(a_mw),
        .ex_alusrc(a_as), .ex_regwrite(a_rw), .ex_aluop(a_aluop)
    );

    id_stage_pipelined #(.XLEN(32), .NREGS(32), .LOAD_STALL(3)) dut_b (
        .clk(clk), .reset(rst_b), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc[31:0]), .flush(flush), .if_stall(b_stall),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data[31:0]),
        .ex_valid(b_valid), .ex_pc(b_pc), .ex_rs1_data(b_rd1),
        .ex_rs2_data(b_rd2), .ex_imm(b_imm), .ex_rs1(b_rs1), .ex_rs2(b_rs2),
        .ex_rd(b_rd), .ex_funct3(b_f3), .ex_funct7(b_f7), .ex_branch(b_br),
        .ex_memread(b_mr), .ex_memtoreg(b_mtr), .ex_memwrite(b_mw),
        .ex_alusrc(b_as), .ex_regwrite(b_rw), .ex_aluop(b_aluop)
    );

    wire         cur_stall = sel ? b_stall : a_stall;
    wire         m_valid   = sel ? b_valid : a_valid;
    wire [63:0]  m_pc  = sel ? {32'd0, b_pc}  : a_pc;
    wire [63:0]  m_a   = sel ? {32'd0, b_rd1} : a_rd1;
    wire [63:0]  m_b   = sel ? {32'd0, b_rd2} : a_rd2;
    wire [63:0]  m_imm = sel ? {32'd0, b_imm} : a_imm;
    wire [4:0]   m_rs1 = sel ? b_rs1 : a_rs1;
    wire [4:0]   m_rs2 = sel ? b_rs2 : a_rs2;
    wire [4:0]   m_rd  = sel ? b_rd  : a_rd;
    wire [2:0]   m_f3  = sel ? b_f3  : a_f3;
    wire [6:0]   m_f7  = sel ? b_f7  : a_f7;
    wire [7:0]   a_ctl = {a_br, a_mr, a_mtr, a_aluop, a_mw, a_as, a_rw};
    wire [7:0]   b_ctl = {b_br, b_mr, b_mtr, b_aluop, b_mw, b_as, b_rw};
    wire [7:0]   m_ctl = sel ? b_ctl : a_ctl;

    task automatic chk(input bit ok, input string nm, input string det);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", nm, det);
    endtask

    task automatic chk_v(input string nm, input logic [63:0] got,
                         input logic [63:0] req);
        chk(got === req, nm, $sformatf("got %h required %h", got, req));
    endtask

    task automatic expect_issue(input logic [63:0] pc, a, b, imm,
                                input int rs1, rs2, rd, f3,
                                input logic [6:0] f7, input logic [7:0] ctl,
                                input int gap);
        exp_t e;
        e.pc = pc; e.a = a; e.b = b; e.imm = imm;
        e.rs1 = 5'(rs1); e.rs2 = 5'(rs2); e.rd = 5'(rd); e.f3 = 3'(f3);
        e.f7 = f7; e.ctl = ctl; e.gap = gap;
        q.push_back(e);
    endtask

    // Present one fetch slot; returns how many cycles it was held by if_stall.
    task automatic feed(input logic v, input logic [31:0] ins,
                        input logic [63:0] pc, output int st);
        st = 0;
        if_valid = v; if_instr = ins; if_pc = pc;
        @(negedge clk);
        while (cur_stall && st < 10) begin
            st++;
            @(negedge clk);
        end
        if (st >= 10) chk(1'b0, "stall_timeout", $sformatf("pc=%h held %0d cycles", pc, st));
        @(posedge clk); #1;
        if_valid = 1'b0;
    endtask

    // Two instructions then an idle slot; total stall cycles returned.
    task automatic grp(input logic [31:0] i0, input logic [63:0] p0,
                       input logic [31:0] i1, input logic [63:0] p1,
                       output int tot);
        int st;
        feed(1'b1, i0, p0, st); tot = st;
        feed(1'b1, i1, p1, st); tot += st;
        feed(1'b0, 32'd0, 64'd0, st); tot += st;
    endtask

    initial begin
        int gap = 0;
        exp_t e;
        bit ok;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_issue", $sformatf("got pc=%h required no issue", m_pc));
                end else begin
                    e = q.pop_front();
                    ok = (m_pc === e.pc) && (m_a === e.a) && (m_b === e.b)
                      && (m_imm === e.imm) && (m_rs1 === e.rs1)
                      && (m_rs2 === e.rs2) && (m_rd === e.rd)
                      && (m_f3 === e.f3) && (m_f7 === e.f7)
                      && (m_ctl === e.ctl) && (e.gap < 0 || e.gap == gap);
                    chk(ok, $sformatf("issue_pc_%0h", e.pc),
                        $sformatf("got pc=%h a=%h b=%h imm=%h rs=%0d,%0d rd=%0d f3=%0d f7=%h ctl=%h gap=%0d required pc=%h a=%h b=%h imm=%h rs=%0d,%0d rd=%0d f3=%0d f7=%h ctl=%h gap=%0d",
                                  m_pc, m_a, m_b, m_imm, m_rs1, m_rs2, m_rd, m_f3, m_f7, m_ctl, gap,
                                  e.pc, e.a, e.b, e.imm, e.rs1, e.rs2, e.rd, e.f3, e.f7, e.ctl, e.gap));
                end
                gap = 0;
            end else begin
                gap++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] LW6   = 32'h0000A303;
    localparam logic [31:0] ADD7  = 32'h002303B3;
    localparam logic [31:0] ADD10 = 32'h00048533;
    localparam logic [31:0] ADD0  = 32'h000003B3;

    initial begin
        int st, tot;
        sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
        if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0;
        wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
        @(negedge clk);
        chk_v("rstA_valid", 64'(a_valid), 64'd0);
        chk_v("rstA_stall", 64'(a_stall), 64'd0);
        chk_v("rstA_imm", a_imm, 64'd0);
        chk_v("rstA_ctl", 64'(a_ctl), 64'd0);
        @(posedge clk); #1;

        expect_issue(64'h100, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 31, 5, 0, 7'h7F, 8'h03, -1);
        feed(1'b1, 32'hFFF00293, 64'h100, st);

        expect_issue(64'h104, 0, 0, 0, 1, 0, 6, 2, 7'h00, 8'h63, -1);
        expect_issue(64'h108, 0, 0, 0, 6, 2, 7, 0, 7'h00, 8'h11, 1);
        grp(LW6, 64'h104, ADD7, 64'h108, tot);
        chk_v("lu_rs1_stalls", 64'(tot), 64'd1);

        expect_issue(64'h10C, 0, 0, 0, 1, 0, 6, 2, 7'h00, 8'h63, -1);
        expect_issue(64'h110, 0, 0, 0, 3, 6, 0, 2, 7'h00, 8'h06, 1);
        grp(LW6, 64'h10C, 32'h0061A023, 64'h110, tot);
        chk_v("lu_rs2_stalls", 64'(tot), 64'd1);

        expect_issue(64'h114, 0, 0, 0, 1, 0, 6, 2, 7'h00, 8'h63, -1);
        expect_issue(64'h118, 0, 0, 64'h1000, 0, 0, 6, 1, 7'h00, 8'h03, 0);
        grp(LW6, 64'h114, 32'h00001337, 64'h118, tot);
        chk_v("lui_no_stall", 64'(tot), 64'd0);

        expect_issue(64'h11C, 0, 0, 0, 1, 0, 0, 2, 7'h00, 8'h63, -1);
        expect_issue(64'h120, 0, 0, 0, 0, 0, 7, 0, 7'h00, 8'h11, 0);
        grp(32'h0000A003, 64'h11C, ADD0, 64'h120, tot);
        chk_v("x0_no_stall", 64'(tot), 64'd0);

        expect_issue(64'h124, 64'h1234, 0, 0, 9, 0, 10, 0, 7'h00, 8'h11, -1);
        expect_issue(64'h128, 0, 0, 0, 0, 0, 7, 0, 7'h00, 8'h11, 0);
        expect_issue(64'h12C, 64'h1234, 0, 0, 9, 0, 10, 0, 7'h00, 8'h11, 0);
        feed(1'b1, ADD10, 64'h124, st);
        wb_regwrite = 1'b1; wb_rd = 5'd9; wb_data = 64'h1234;
        feed(1'b1, ADD0, 64'h128, st);
        wb_rd = 5'd0; wb_data = 64'hDEAD;
        feed(1'b1, ADD10, 64'h12C, st);
        wb_regwrite = 1'b0;
        feed(1'b0, 32'd0, 64'd0, st);

        expect_issue(64'h130, 0, 0, 0, 1, 0, 6, 2, 7'h00, 8'h63, -1);
        feed(1'b1, LW6, 64'h130, st);
        feed(1'b1, ADD7, 64'h134, st);
        @(negedge clk);
        chk_v("rst_mid_stall_on", 64'(a_stall), 64'd1);
        rst_a = 1'b1;
        @(posedge clk); #1 rst_a = 1'b0;
        @(negedge clk);
        chk_v("rst_mid_valid", 64'(a_valid), 64'd0);
        chk_v("rst_mid_stall", 64'(a_stall), 64'd0);
        @(posedge clk); #1;
        expect_issue(64'h138, 0, 0, 0, 9, 0, 10, 0, 7'h00, 8'h11, -1);
        feed(1'b1, ADD10, 64'h138, st);
        feed(1'b0, 32'd0, 64'd0, st);
        repeat (2) @(posedge clk);
        #1;

        sel = 1'b1; rst_a = 1'b1;
        @(posedge clk); #1 rst_b = 1'b0;
        @(negedge clk);
        chk_v("rstB_valid", 64'(b_valid), 64'd0);
        @(posedge clk); #1;

        expect_issue(64'h200, 0, 0, 64'hFFFF_FFFC, 0, 0, 29, 0, 7'h7F, 8'h88, -1);
        feed(1'b1, 32'hFE000EE3, 64'h200, st);
        expect_issue(64'h204, 0, 0, 0, 1, 0, 6, 2, 7'h00, 8'h63, -1);
        expect_issue(64'h208, 0, 0, 0, 6, 2, 7, 0, 7'h00, 8'h11, 3);
        grp(LW6, 64'h204, ADD7, 64'h208, tot);
        chk_v("lu3_stalls", 64'(tot), 64'd3);

        expect_issue(64'h20C, 0, 0, 0, 1, 0, 6, 2, 7'h00, 8'h63, -1);
        feed(1'b1, LW6, 64'h20C, st);
        feed(1'b1, ADD7, 64'h210, st);
        @(negedge clk);
        chk_v("fl_stall_c1", 64'(b_stall), 64'd1);
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        chk_v("fl_stall_c2", 64'(b_stall), 64'd1);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk_v("fl_stall_after", 64'(b_stall), 64'd0);
        chk_v("fl_valid_after", 64'(b_valid), 64'd0);
        @(posedge clk); #1;
        expect_issue(64'h214, 0, 0, 0, 9, 0, 10, 0, 7'h00, 8'h11, -1);
        feed(1'b1, ADD10, 64'h214, st);
        feed(1'b0, 32'd0, 64'd0, st);

        repeat (4) @(negedge clk);
        chk_v("queue_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
